// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset. dout shows the head entry
// combinationally so a pop can load it on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-attached 8N1 UART transmitter: register file, TX FIFO, baud counter and
// framing FSM. Stores to TXDATA queue bytes; the FSM drains them back to back.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: req_ready is constantly 1, so every cycle with req_valid is a
    // transfer; exactly one rsp_valid pulse follows on the next cycle.
    assign req_ready = 1'b1;

    uart_tx_state_t state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           enable;
    logic           overflow;

    logic [3:0]     off;
    logic           wr;
    logic           push;
    logic           pop;
    logic           baud_end;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status;
    logic [31:0]    rdata_next;
    logic           addr_unused;

    assign off         = {req_addr[3:2], 2'b00};
    assign wr          = req_valid && req_we;
    assign push        = wr && (off == UART_TXDATA);
    assign baud_end    = (baud == BW'(CLKS_PER_BIT - 1));
    assign pop         = enable && !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && baud_end));
    assign addr_unused = ^{req_addr[1:0], req_wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (req_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                = '0;
        status[ST_FULL]       = fifo_full;
        status[ST_EMPTY]      = fifo_empty;
        status[ST_BUSY]       = (state != IDLE);
        status[ST_OVF]        = overflow;
        status[ST_COUNT +: 4] = 4'(fifo_count);
        rdata_next            = '0;
        if (req_valid && !req_we) begin
            case (off)
                UART_STATUS: rdata_next = status;
                UART_CTRL:   rdata_next = {31'b0, enable};
                default:     rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            enable    <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            rsp_valid <= req_valid;
            rsp_rdata <= rdata_next;
            if (wr && (off == UART_CTRL)) begin
                enable <= req_wdata[0];
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr && (off == UART_STATUS) && req_wdata[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= fifo_dout;
                        baud  <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        // Chain straight into the next start bit when a byte is waiting.
                        if (pop) begin
                            shift <= fifo_dout;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic, all checked
// against a frame-level model (byte queue + frame start time) every cycle.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .tx        (tx)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic chk_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: a byte queue and the start time of the frame on the wire
    logic [7:0]  mq[$];
    logic        m_en = 1'b1;
    logic        m_ovf = 1'b0;
    logic        m_active = 1'b0;
    int          m_start = 0;
    int          cyc = 0;
    logic [9:0]  m_frame = 10'h3ff;
    logic        exp_tx = 1'b1;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a & 4'hC)
            4'h4: r = {24'h0, 4'(mq.size()), m_ovf, m_active,
                       (mq.size() == 0), (mq.size() == DEPTH)};
            4'h8: r = {31'h0, m_en};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic       do_pop;
        logic       pre_full;
        logic [7:0] b;
        cyc++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_en     = 1'b1;
            m_ovf    = 1'b0;
            m_active = 1'b0;
            exp_rv   = 1'b0;
        end else begin
            exp_rv = req_valid;
            if (req_valid) begin
                exp_q.push_back(req_we ? 32'h0 : model_read(req_addr));
            end
            if (m_active && (cyc - m_start == 10 * CPB)) begin
                m_active = 1'b0;
            end
            pre_full = (mq.size() == DEPTH);
            do_pop   = m_en && (mq.size() > 0) && !m_active;
            if (do_pop) begin
                b        = mq.pop_front();
                m_frame  = {1'b1, b, 1'b0};
                m_start  = cyc;
                m_active = 1'b1;
            end
            if (req_valid && req_we) begin
                case (req_addr & 4'hC)
                    4'h0: begin
                        if (!pre_full || do_pop) mq.push_back(req_wdata[7:0]);
                        else m_ovf = 1'b1;
                    end
                    4'h4: if (req_wdata[3]) m_ovf = 1'b0;
                    4'h8: m_en = req_wdata[0];
                    default: ;
                endcase
            end
        end
        exp_tx = m_active ? m_frame[(cyc - m_start) / CPB] : 1'b1;
    end

    // scoreboard: every cycle compare line and response against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("tx", {31'h0, tx}, {31'h0, exp_tx});
            check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv});
            check("req_ready", {31'h0, req_ready}, 32'h1);
            if (exp_rv && exp_q.size() > 0) begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic bus_drive(input logic we, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_drive(1'b0, a, 32'h0);
        @(negedge clk);
        d = rsp_rdata;
        req_valid = 1'b0;
    endtask

    logic [31:0] d;
    logic [9:0]  fr;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;

        // reset then idle
        bus_idle(5);
        bus_read(4'h4, d);
        check("rst_status", d, 32'h2);
        bus_read(4'h8, d);
        check("rst_ctrl", d, 32'h1);

        // single byte 0xA5
        fr = {1'b1, 8'hA5, 1'b0};
        bus_drive(1'b1, 4'h0, 32'hA5);
        bus_idle(1);
        check("tx_before_fall", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("tx_fall", {31'h0, tx}, 32'h0);
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            check("a5_bit", {31'h0, tx}, {31'h0, fr[i]});
        end
        repeat (CPB) @(negedge clk);
        bus_read(4'h4, d);
        check("a5_busy_clear", d, 32'h2);

        // six back-to-back stores: one popped, four queued, one dropped
        for (int i = 1; i <= 6; i++) bus_drive(1'b1, 4'h0, i);
        bus_read(4'h4, d);
        check("six_status", d, 32'h4D);
        bus_drive(1'b1, 4'h4, 32'h8);
        bus_read(4'h4, d);
        check("ovf_clear", {31'h0, d[3]}, 32'h0);
        bus_idle(5 * 10 * CPB + 10);
        bus_read(4'h4, d);
        check("six_drained", d, 32'h2);

        // disable, queue, re-enable
        bus_drive(1'b1, 4'h8, 32'h0);
        bus_drive(1'b1, 4'h0, 32'h55);
        bus_read(4'h4, d);
        check("dis_status", d, 32'h10);
        bus_idle(20);
        check("dis_tx_high", {31'h0, tx}, 32'h1);
        bus_drive(1'b1, 4'h8, 32'h1);
        bus_idle(1);
        check("en_tx_pre", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("en_tx_start", {31'h0, tx}, 32'h0);
        bus_idle(10 * CPB + 5);

        // reset in the 15th cycle of a frame with a second byte queued
        bus_drive(1'b1, 4'h0, 32'h3C);
        bus_drive(1'b1, 4'h0, 32'h77);
        bus_idle(1);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", {31'h0, tx}, 32'h1);
        bus_read(4'h4, d);
        check("rst_mid_status", d, 32'h2);
        bus_idle(60);
        check("rst_mid_quiet", {31'h0, tx}, 32'h1);

        // unmapped offset 0xC
        bus_read(4'hC, d);
        check("c_load", d, 32'h0);
        bus_drive(1'b1, 4'hC, 32'hFFFF_FFFF);
        bus_read(4'h4, d);
        check("c_status", d, 32'h2);
        bus_read(4'h8, d);
        check("c_ctrl", d, 32'h1);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            int op;
            logic [31:0] rd;
            op = $urandom_range(0, 9);
            rd = $urandom;
            case (op)
                0, 1, 2, 3, 4: bus_drive(1'b1, 4'h0, rd);
                5: bus_drive(1'b0, 4'h4, 32'h0);
                6: bus_drive(1'b1, 4'h8, {rd[31:1], ($urandom_range(0, 99) < 85)});
                7: bus_drive(1'b1, 4'h4, rd);
                8: bus_drive(1'b0, 4'({$urandom_range(0, 3), 2'b00}), 32'h0);
                default: bus_drive(rd[0], 4'hC, rd);
            endcase
            bus_idle($urandom_range(0, 3) == 0 ? $urandom_range(10, 40) : $urandom_range(0, 3));
        end
        bus_drive(1'b1, 4'h8, 32'h1);
        bus_idle(DEPTH * 10 * CPB + 100);
        bus_read(4'h4, d);
        check("final_empty", {31'h0, d[1]}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
